// File: rtl/pipe_stage_buffer_pkg.sv
// Shared pipeline-register definitions: bubble encoding, occupancy states and
// per-stage default payload widths.
package pipe_stage_buffer_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 16;

    localparam int IFID_DATA_W  = 64;
    localparam int IFID_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 128;
    localparam int IDEX_CTRL_W  = 24;
    localparam int EXMEM_DATA_W = 96;
    localparam int EXMEM_CTRL_W = 16;
    localparam int MEMWB_DATA_W = 64;
    localparam int MEMWB_CTRL_W = 8;

    // All-zero control word: no register-file, memory or flag write can fire.
    localparam logic [DEF_CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    // State encodings equal the entry count, so occupancy is the raw code.
    function automatic logic [1:0] occ_of(input occ_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: data+control payload register with write-enable,
// cleared by the asynchronous active-low reset.
module pipe_entry_reg #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_we,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush
// and an optional two-entry skid buffer; control is forced to a bubble when empty.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | nothing held, out_valid low, out_ctrl bubble
//   ST_ONE   | main entry valid
//   ST_TWO   | main (older) and skid (younger) valid, in_ready low
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [1:0]        o_occupancy
);

    localparam int ENT_W = DATA_W + CTRL_W;

    occ_state_e       r_state;
    occ_state_e       w_state_nxt;
    logic             w_accept;
    logic             w_drain;
    logic             w_main_we;
    logic             w_main_from_skid;
    logic [ENT_W-1:0] w_in_payload;
    logic [ENT_W-1:0] w_main_d;
    logic [ENT_W-1:0] w_main_q;
    logic [ENT_W-1:0] w_skid_q;

    assign w_in_payload = {i_in_data, i_in_ctrl};
    assign o_out_valid  = (r_state != ST_EMPTY);
    assign w_accept     = i_in_valid & o_in_ready;
    assign w_drain      = o_out_valid & i_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush only moves the state; payloads left behind are unreachable.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_we        = 1'b0;
        w_main_from_skid = 1'b0;
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_we   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_we = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        w_state_nxt      = ST_ONE;
                        w_main_we        = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_payload;

    pipe_entry_reg #(.W(ENT_W)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .i_we  (w_main_we),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic r_in_ready;
            logic w_skid_we;

            // Registered ready breaks the combinational path from downstream ready.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != ST_TWO);
                end
            end

            assign o_in_ready = r_in_ready & ~i_flush;
            assign w_skid_we  = (r_state == ST_ONE) & w_accept & ~w_drain;

            pipe_entry_reg #(.W(ENT_W)) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .i_we  (w_skid_we),
                .i_d   (w_in_payload),
                .o_q   (w_skid_q)
            );
        end else begin : g_no_skid
            assign o_in_ready = (~o_out_valid | i_out_ready) & ~i_flush;
            assign w_skid_q   = '0;
        end
    endgenerate

    assign o_out_data  = w_main_q[ENT_W-1:CTRL_W];
    assign o_out_ctrl  = o_out_valid ? w_main_q[CTRL_W-1:0] : CTRL_W'(CTRL_BUBBLE);
    assign o_occupancy = occ_of(r_state);

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: skid and pass-through builds side by side, a FIFO
// scoreboard per build, a per-cycle vector table and hand-written corner sequences.
module tb_pipe_stage_buffer;

    localparam int DW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          flush, in_valid, out_ready, in_ready, out_valid;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occ;

    logic          flush0, in_valid0, out_ready0, in_ready0, out_valid0;
    logic [DW-1:0] in_data0, out_data0;
    logic [CW-1:0] in_ctrl0, out_ctrl0;
    logic [1:0]    occ0;

    pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .i_in_data(in_data), .i_in_ctrl(in_ctrl),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_out_ctrl(out_ctrl), .o_occupancy(occ)
    );

    pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_flush(flush0), .i_in_valid(in_valid0),
        .o_in_ready(in_ready0), .i_in_data(in_data0), .i_in_ctrl(in_ctrl0),
        .o_out_valid(out_valid0), .i_out_ready(out_ready0), .o_out_data(out_data0),
        .o_out_ctrl(out_ctrl0), .o_occupancy(occ0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
        return 16'h1000 | d[15:0];
    endfunction

    // Scoreboards: payload pushed on accept, popped and compared on drain.
    logic [DW+CW-1:0] q1[$];
    logic [DW+CW-1:0] q0[$];
    logic [DW+CW-1:0] e1, e0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
        end else begin
            chk("skid_occ_vs_model", 32'(occ), 32'(q1.size()));
            if (!out_valid) chk("skid_bubble_ctrl", 32'(out_ctrl), 32'd0);
            if (out_valid && out_ready) begin
                if (q1.size() == 0) begin
                    chk("skid_drain_with_empty_model", 32'(out_valid), 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    chk("skid_sb_data", out_data, e1[DW+CW-1:CW]);
                    chk("skid_sb_ctrl", 32'(out_ctrl), 32'(e1[CW-1:0]));
                end
            end
            if (flush) q1.delete();
            if (in_valid && in_ready) q1.push_back({in_data, in_ctrl});
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
        end else begin
            chk("pass_occ_vs_model", 32'(occ0), 32'(q0.size()));
            if (!out_valid0) chk("pass_bubble_ctrl", 32'(out_ctrl0), 32'd0);
            if (out_valid0 && out_ready0) begin
                if (q0.size() == 0) begin
                    chk("pass_drain_with_empty_model", 32'(out_valid0), 32'd0);
                end else begin
                    e0 = q0.pop_front();
                    chk("pass_sb_data", out_data0, e0[DW+CW-1:CW]);
                    chk("pass_sb_ctrl", 32'(out_ctrl0), 32'(e0[CW-1:0]));
                end
            end
            if (flush0) q0.delete();
            if (in_valid0 && in_ready0) q0.push_back({in_data0, in_ctrl0});
        end
    end

    typedef struct {
        logic          vld;
        logic          rdy;
        logic [DW-1:0] data;
        logic [1:0]    exp_occ;
        logic          exp_irdy;
        logic          exp_ov;
        logic [DW-1:0] exp_od;
    } vec_t;

    localparam int NV = 12;
    vec_t tv[NV];

    function automatic vec_t mk(input logic v, input logic r, input logic [DW-1:0] d,
                                input logic [1:0] o, input logic ir, input logic ov,
                                input logic [DW-1:0] od);
        vec_t t;
        t.vld = v; t.rdy = r; t.data = d; t.exp_occ = o;
        t.exp_irdy = ir; t.exp_ov = ov; t.exp_od = od;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = ctrl_of(d);
        out_ready = r;
    endtask

    initial begin
        //        vld   rdy   data   occ   irdy  ov    out_data
        tv[0]  = mk(1'b1, 1'b1, 32'd1, 2'd1, 1'b1, 1'b1, 32'd1);
        tv[1]  = mk(1'b1, 1'b1, 32'd2, 2'd1, 1'b1, 1'b1, 32'd2);
        tv[2]  = mk(1'b1, 1'b1, 32'd3, 2'd1, 1'b1, 1'b1, 32'd3);
        tv[3]  = mk(1'b1, 1'b1, 32'd4, 2'd1, 1'b1, 1'b1, 32'd4);
        tv[4]  = mk(1'b0, 1'b1, 32'd0, 2'd0, 1'b1, 1'b0, 32'd4);
        tv[5]  = mk(1'b1, 1'b1, 32'd5, 2'd1, 1'b1, 1'b1, 32'd5);
        tv[6]  = mk(1'b1, 1'b0, 32'd6, 2'd2, 1'b0, 1'b1, 32'd5);
        tv[7]  = mk(1'b1, 1'b0, 32'd7, 2'd2, 1'b0, 1'b1, 32'd5);
        tv[8]  = mk(1'b1, 1'b0, 32'd7, 2'd2, 1'b0, 1'b1, 32'd5);
        tv[9]  = mk(1'b1, 1'b1, 32'd7, 2'd1, 1'b1, 1'b1, 32'd6);
        tv[10] = mk(1'b1, 1'b1, 32'd7, 2'd1, 1'b1, 1'b1, 32'd7);
        tv[11] = mk(1'b0, 1'b1, 32'd0, 2'd0, 1'b1, 1'b0, 32'd7);

        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b1; in_data = 32'hDEAD; in_ctrl = 16'h0A5A; out_ready = 1'b0;
        flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0; in_ctrl0 = '0; out_ready0 = 1'b1;

        // Reset held with traffic present
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_pass_occ", 32'(occ0), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_pass_in_ready", 32'(in_ready0), 32'd1);
        tick();
        chk("rel_first_valid", 32'(out_valid), 32'd1);
        chk("rel_first_data", out_data, 32'hDEAD);
        chk("rel_first_ctrl", 32'(out_ctrl), 32'h0A5A);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("rel_drained", 32'(occ), 32'd0);

        // Streaming then stall/release through the vector table
        for (int i = 0; i < NV; i++) begin
            drive(tv[i].vld, tv[i].data, tv[i].rdy);
            tick();
            chk($sformatf("tv%0d_occ", i), 32'(occ), 32'(tv[i].exp_occ));
            chk($sformatf("tv%0d_in_ready", i), 32'(in_ready), 32'(tv[i].exp_irdy));
            chk($sformatf("tv%0d_out_valid", i), 32'(out_valid), 32'(tv[i].exp_ov));
            chk($sformatf("tv%0d_out_data", i), out_data, tv[i].exp_od);
            chk($sformatf("tv%0d_out_ctrl", i), 32'(out_ctrl),
                tv[i].exp_ov ? 32'(ctrl_of(tv[i].exp_od)) : 32'd0);
        end

        // Flush with two entries held; head drains in the flush cycle
        drive(1'b1, 32'd8, 1'b0);
        tick();
        drive(1'b1, 32'd9, 1'b0);
        tick();
        chk("fl_pre_occ", 32'(occ), 32'd2);
        flush = 1'b1;
        drive(1'b1, 32'd10, 1'b1);
        #1;
        chk("fl_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_out_ctrl", 32'(out_ctrl), 32'd0);
        chk("fl_occ", 32'(occ), 32'd0);
        flush = 1'b0;
        drive(1'b0, 32'd0, 1'b1);
        #1;
        chk("fl_in_ready_back", 32'(in_ready), 32'd1);
        tick();
        chk("fl_nothing_accepted", 32'(occ), 32'd0);

        // Flush from one entry: ready must be forced low by flush itself
        drive(1'b1, 32'h0B, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h0C, 1'b0);
        #1;
        chk("fl1_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("fl1_occ", 32'(occ), 32'd0);
        chk("fl1_out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        drive(1'b0, 32'd0, 1'b1);
        tick();
        chk("fl1_still_empty", 32'(occ), 32'd0);

        // Bubble after an all-ones control word; unknown inputs while idle
        in_valid = 1'b1; in_data = 32'h55; in_ctrl = 16'hFFFF; out_ready = 1'b0;
        tick();
        chk("bub_ctrl_live", 32'(out_ctrl), 32'h0000FFFF);
        in_valid = 1'b0; in_data = 'x; in_ctrl = 'x; out_ready = 1'b1;
        tick();
        chk("bub_out_valid", 32'(out_valid), 32'd0);
        chk("bub_out_ctrl", 32'(out_ctrl), 32'd0);
        chk("bub_data_held", out_data, 32'h55);
        tick();
        chk("bub_x_idle_ctrl", 32'(out_ctrl), 32'd0);
        drive(1'b0, 32'd0, 1'b1);

        // Reset while two entries are held
        drive(1'b1, 32'h20, 1'b0);
        tick();
        drive(1'b1, 32'h21, 1'b0);
        tick();
        chk("mrst_pre_occ", 32'(occ), 32'd2);
        drive(1'b0, 32'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_occ", 32'(occ), 32'd0);
        chk("mrst_out_data", out_data, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("mrst_nothing_survives", 32'(occ), 32'd0);

        // Pass-through build: ready follows downstream in the same cycle
        in_valid0 = 1'b1; in_data0 = 32'h100; in_ctrl0 = ctrl_of(32'h100); out_ready0 = 1'b1;
        tick();
        chk("p_first_occ", 32'(occ0), 32'd1);
        chk("p_first_data", out_data0, 32'h100);
        in_data0 = 32'h101; in_ctrl0 = ctrl_of(32'h101); out_ready0 = 1'b0;
        #1;
        chk("p_ready_drops", 32'(in_ready0), 32'd0);
        tick();
        chk("p_stall_occ", 32'(occ0), 32'd1);
        chk("p_stall_data", out_data0, 32'h100);
        out_ready0 = 1'b1;
        #1;
        chk("p_ready_rises", 32'(in_ready0), 32'd1);
        tick();
        chk("p_swap_occ", 32'(occ0), 32'd1);
        chk("p_swap_data", out_data0, 32'h101);
        chk("p_swap_ctrl", 32'(out_ctrl0), 32'(ctrl_of(32'h101)));
        in_valid0 = 1'b0;
        tick();
        chk("p_empty_occ", 32'(occ0), 32'd0);
        chk("p_empty_ctrl", 32'(out_ctrl0), 32'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
